// File: rtl/bus_arb_pkg.sv
// Shared widths, FSM encoding and constants for the two-master bus arbiter.
// Imported by the arbiter top and its wait timer.
package bus_arb_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 4;

  // Read data handed back to a master whose access was aborted by the timer.
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS0 = 2'd1,
    S_BUS1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // A master is requesting only when exactly one strobe is high.
  function automatic logic is_req(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/bus_arb_timer.sv
// Wait-state counter for a granted access; flags the cycle in which the
// TIMEOUT-th consecutive ready-low bus cycle occurs (TIMEOUT = 0 disables).
module bus_arb_timer
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic             ENABLED   = (TIMEOUT != 0);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // en already excludes ready, so a coincident ready always wins.
  assign expired = ENABLED && en && (count == LAST_WAIT);

endmodule

// File: rtl/bus_arb.sv
// Two-master, single-slave bus arbiter with alternating priority, fully
// registered outputs and an optional slave-wait timeout.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_data_out,
  input  logic              m0_read,
  input  logic              m0_write,
  output logic [DATA_W-1:0] m0_data_in,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_data_out,
  input  logic              m1_read,
  input  logic              m1_write,
  output logic [DATA_W-1:0] m1_data_in,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready,
  output logic [1:0]        grant,
  output logic              err,
  output state_t            fsm_state
);

  // Handshake: a master holds exactly one of read/write high (level) until it
  // sees its one-cycle mx_ready; the slave completes a bus access by raising
  // ready while read or write is high, and ready at any other time is ignored.

  state_t            state, next_state;
  logic              last, next_last;
  logic [ADDR_W-1:0] add_buf, next_add_buf;
  logic [DATA_W-1:0] data_buf, next_data_buf;
  logic              dir, next_dir;
  logic              next_read, next_write, next_err;
  logic [1:0]        next_grant;
  logic [DATA_W-1:0] next_m0_data_in, next_m1_data_in;
  logic              next_m0_ready, next_m1_ready;
  logic [DATA_W-1:0] done_rdata;

  logic m0_req, m1_req, pick0, pick1;
  logic busy, timer_clr, timer_en, expired;

  assign m0_req = is_req(m0_read, m0_write);
  assign m1_req = is_req(m1_read, m1_write);
  // last = 1 means m1 owned the bus most recently, so m0 wins a tie.
  assign pick0  = m0_req && (!m1_req || last);
  assign pick1  = m1_req && !pick0;

  assign busy      = (state == S_BUS0) || (state == S_BUS1);
  assign timer_clr = !busy;
  assign timer_en  = busy && !ready;

  bus_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_comb begin
    next_state      = state;
    next_last       = last;
    next_add_buf    = add_buf;
    next_data_buf   = data_buf;
    next_dir        = dir;
    next_read       = read;
    next_write      = write;
    next_grant      = grant;
    next_err        = 1'b0;
    next_m0_ready   = 1'b0;
    next_m1_ready   = 1'b0;
    next_m0_data_in = m0_data_in;
    next_m1_data_in = m1_data_in;
    done_rdata      = ready ? data_in : TIMEOUT_RDATA;

    case (state)
      S_IDLE: begin
        if (pick0) begin
          next_state    = S_BUS0;
          next_add_buf  = m0_address;
          next_data_buf = m0_data_out;
          next_dir      = m0_write;
          next_read     = m0_read;
          next_write    = m0_write;
          next_grant    = 2'b01;
        end else if (pick1) begin
          next_state    = S_BUS1;
          next_add_buf  = m1_address;
          next_data_buf = m1_data_out;
          next_dir      = m1_write;
          next_read     = m1_read;
          next_write    = m1_write;
          next_grant    = 2'b10;
        end
      end

      S_BUS0, S_BUS1: begin
        if (ready || expired) begin
          next_state = S_DONE;
          next_read  = 1'b0;
          next_write = 1'b0;
          next_grant = 2'b00;
          next_err   = !ready;
          next_last  = (state == S_BUS1);
          if (state == S_BUS0) begin
            next_m0_ready = 1'b1;
            if (!dir) next_m0_data_in = done_rdata;
          end else begin
            next_m1_ready = 1'b1;
            if (!dir) next_m1_data_in = done_rdata;
          end
        end
      end

      // Guaranteed idle cycle so a master dropping its request on mx_ready
      // is never sampled as still requesting.
      S_DONE: next_state = S_IDLE;

      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last       <= 1'b1;
      add_buf    <= '0;
      data_buf   <= '0;
      dir        <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      grant      <= 2'b00;
      err        <= 1'b0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      m0_data_in <= '0;
      m1_data_in <= '0;
    end else begin
      state      <= next_state;
      last       <= next_last;
      add_buf    <= next_add_buf;
      data_buf   <= next_data_buf;
      dir        <= next_dir;
      read       <= next_read;
      write      <= next_write;
      grant      <= next_grant;
      err        <= next_err;
      m0_ready   <= next_m0_ready;
      m1_ready   <= next_m1_ready;
      m0_data_in <= next_m0_data_in;
      m1_data_in <= next_m1_data_in;
    end
  end

  assign address   = add_buf;
  assign data_out  = data_buf;
  assign fsm_state = state;

endmodule

// File: tb/tb_bus_arb.sv
// Directed and randomized checks of bus_arb against a transaction-level model
// of arbitration order, wait/timeout rules and returned read data.
module tb_bus_arb;
  import bus_arb_pkg::*;

  localparam int TIMEOUT = 15;

  logic       clk, reset;
  logic [7:0] m0_address, m0_data_out, m1_address, m1_data_out;
  logic       m0_read, m0_write, m1_read, m1_write;
  logic [7:0] m0_data_in, m1_data_in;
  logic       m0_ready, m1_ready;
  logic [7:0] address, data_out, data_in;
  logic       read, write, ready, err;
  logic [1:0] grant;
  state_t     fsm_state;

  int         n_assert, n_fail;
  int         prev_owner;
  logic [7:0] exp_din[2];

  bus_arb #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_data_out(m0_data_out), .m0_read(m0_read), .m0_write(m0_write),
    .m0_data_in(m0_data_in), .m0_ready(m0_ready),
    .m1_address(m1_address), .m1_data_out(m1_data_out), .m1_read(m1_read), .m1_write(m1_write),
    .m1_data_in(m1_data_in), .m1_ready(m1_ready),
    .address(address), .data_out(data_out), .read(read), .write(write),
    .data_in(data_in), .ready(ready), .grant(grant), .err(err), .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int m, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_data_out = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_data_out = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the grant edge. Model: the slave answers after
  // `waits` ready-low cycles unless waits >= TIMEOUT, in which case the access
  // is aborted after exactly TIMEOUT ready-low cycles.
  task automatic txn_check(input int m, input logic [7:0] addr, input logic wr,
                           input logic [7:0] wdata, input int waits,
                           input logic [7:0] rdata, input bit drop_early);
    bit         to;
    int         n_bus;
    logic [1:0] g;
    logic [7:0] exp_d;
    to    = (TIMEOUT != 0) && (waits >= TIMEOUT);
    n_bus = to ? TIMEOUT : waits + 1;
    g     = (m == 0) ? 2'b01 : 2'b10;
    for (int c = 0; c < n_bus; c++) begin
      ready   = (!to && c == n_bus - 1);
      data_in = ready ? rdata : 8'($urandom);
      if (c == 0) begin
        if (drop_early) set_req(m, 1'b0, 1'b0, 8'h00, 8'h00);
        else            set_req(m, !wr, wr, ~addr, ~wdata);
      end
      @(negedge clk);
      chk("bus_grant", grant, g);
      chk("bus_read", read, !wr);
      chk("bus_write", write, wr);
      chk("bus_address", address, addr);
      if (wr) chk("bus_data_out", data_out, wdata);
      chk("bus_m0_ready", m0_ready, 0);
      chk("bus_m1_ready", m1_ready, 0);
      chk("bus_err", err, 0);
      tick();
    end
    ready = 1'b0;
    exp_d = wr ? exp_din[m] : (to ? 8'hFF : rdata);
    exp_din[m] = exp_d;
    prev_owner = m;
    @(negedge clk);
    chk("done_own_ready", (m == 0) ? m0_ready : m1_ready, 1);
    chk("done_other_ready", (m == 0) ? m1_ready : m0_ready, 0);
    chk("done_err", err, to);
    chk("done_grant", grant, 0);
    chk("done_strobes", {read, write}, 0);
    chk("done_m0_data_in", m0_data_in, exp_din[0]);
    chk("done_m1_data_in", m1_data_in, exp_din[1]);
    tick();
    set_req(m, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("gap_grant", grant, 0);
    chk("gap_ready", {m0_ready, m1_ready}, 0);
    chk("gap_err", err, 0);
  endtask

  initial begin
    int         pick, win, lose;
    logic [7:0] a[2], d[2], rd[2];
    logic       w[2];
    int         wt[2];
    bit         de;

    n_assert = 0; n_fail = 0;
    prev_owner = 1; exp_din[0] = 8'h00; exp_din[1] = 8'h00;
    reset = 1'b1; ready = 1'b0; data_in = 8'h00;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset values
    #2 reset = 1'b0;
    #1;
    chk("rst_address", address, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_m0_data_in", m0_data_in, 0);
    chk("rst_m1_data_in", m1_data_in, 0);
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_ready", m1_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_grant", grant, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);

    // Simultaneous writes after reset: m0 first, then m1
    set_req(0, 1'b0, 1'b1, 8'h20, 8'h11);
    set_req(1, 1'b0, 1'b1, 8'h21, 8'h22);
    tick();
    txn_check(0, 8'h20, 1'b1, 8'h11, 0, 8'h00, 1'b0);
    set_req(1, 1'b0, 1'b1, 8'h21, 8'h22);
    tick();
    txn_check(1, 8'h21, 1'b1, 8'h22, 1, 8'h00, 1'b0);

    // m0 read, slave ready after 2 wait cycles
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    txn_check(0, 8'h10, 1'b0, 8'h00, 2, 8'hA5, 1'b0);

    // m1 read with a slave that never answers
    set_req(1, 1'b1, 1'b0, 8'h44, 8'h00);
    tick();
    txn_check(1, 8'h44, 1'b0, 8'h00, 40, 8'h00, 1'b0);

    // ready arrives in the very cycle the timer would fire
    set_req(0, 1'b1, 1'b0, 8'h55, 8'h00);
    tick();
    txn_check(0, 8'h55, 1'b0, 8'h00, TIMEOUT - 1, 8'h5C, 1'b0);

    // m0 with both strobes is not a request; m1 is served
    set_req(0, 1'b1, 1'b1, 8'h66, 8'h99);
    set_req(1, 1'b0, 1'b1, 8'h67, 8'h3A);
    tick();
    txn_check(1, 8'h67, 1'b1, 8'h3A, 1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("both_hi_grant", grant, 0);
      chk("both_hi_strobes", {read, write}, 0);
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);

    // ready while idle is ignored
    tick();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_rdy_grant", grant, 0);
      chk("idle_rdy_mready", {m0_ready, m1_ready, err}, 0);
    end
    tick();
    ready = 1'b0;

    // Reset in the middle of an m1 wait
    set_req(1, 1'b1, 1'b0, 8'h77, 8'h00);
    tick();
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("midrst_strobes", {read, write}, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_m1_ready", m1_ready, 0);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("midrst_m1_ready_hold", m1_ready, 0);
    chk("midrst_m1_data_in", m1_data_in, 0);
    chk("midrst_m0_data_in", m0_data_in, 0);
    exp_din[0] = 8'h00; exp_din[1] = 8'h00; prev_owner = 1;
    reset = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 8'h3C, 8'h00);
    tick();
    txn_check(0, 8'h3C, 1'b0, 8'h00, 1, 8'h96, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      pick = $urandom_range(0, 2);
      for (int k = 0; k < 2; k++) begin
        a[k]  = 8'($urandom);
        d[k]  = 8'($urandom);
        rd[k] = 8'($urandom);
        w[k]  = 1'($urandom);
        wt[k] = ($urandom_range(0, 6) == 0) ? int'($urandom_range(13, 17))
                                            : int'($urandom_range(0, 4));
        if (pick == 2 || pick == k) set_req(k, !w[k], w[k], a[k], d[k]);
      end
      de = ($urandom_range(0, 3) == 0);
      tick();
      if (pick == 2) begin
        win  = (prev_owner == 1) ? 0 : 1;
        lose = 1 - win;
        txn_check(win, a[win], w[win], d[win], wt[win], rd[win], de);
        tick();
        txn_check(lose, a[lose], w[lose], d[lose], wt[lose], rd[lose], 1'b0);
      end else begin
        txn_check(pick, a[pick], w[pick], d[pick], wt[pick], rd[pick], de);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum BUSx cycles without ready (1..15); 0 disables timeout.
REQ-002 clk  in  1  system clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 m0_address, m1_address  in  8  master address.
REQ-005 m0_data_out, m1_data_out  in  8  master write data.
REQ-006 m0_read, m1_read / m0_write, m1_write  in  1  master request strobes, level, held until ready.
REQ-007 m0_data_in, m1_data_in  out  8  registered read data returned to master.
REQ-008 m0_ready, m1_ready  out  1  one-cycle completion pulse to master.
REQ-009 address, data_out  out  8  shared bus address / write data.
REQ-010 read, write  out  1  shared bus strobes.
REQ-011 data_in  in  8  shared bus read data.
REQ-012 ready  in  1  slave completion.
REQ-013 grant  out  2  one-hot current bus owner; 00 when idle.
REQ-014 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 A master requests when exactly one of read/write is high; both high is ignored (no grant).
REQ-016 States: IDLE, BUS0, BUS1, DONE; all outputs registered.
REQ-017 IDLE: only m0 requests -> BUS0; only m1 -> BUS1; both -> master not in `last`; none -> stay.
REQ-018 On leaving IDLE, latch address, write data, direction into add_buf/data_buf/dir; bus outputs driven from latches.
REQ-019 Latency: request sampled in IDLE at edge n -> read/write high and grant set from cycle n+1.
REQ-020 BUSx: read/write held until ready sampled high; master inputs ignored while granted.
REQ-021 ready high in BUSx -> DONE: mx_ready high one cycle, read/write/grant low, mx_data_in <= data_in on reads (unchanged on writes), last <= x.
REQ-022 DONE -> IDLE unconditionally; one idle bus cycle separates transactions, so a master clearing its request on mx_ready is never re-granted.
REQ-023 Master dropping its request while granted does not abort; transaction completes, mx_ready still pulses.
REQ-024 Wait counter (4-bit) clears on entering BUSx, increments each BUSx cycle with ready low.
REQ-025 Counter reaching TIMEOUT (TIMEOUT != 0) with ready low -> DONE with mx_ready and err pulsed; reads return 8'hFF.
REQ-026 ready and timeout in same cycle: ready wins, no err.
REQ-027 ready high outside BUSx is ignored.
REQ-028 Alternation: continuous requests from both masters yield m0, m1, m0, ... grants.

Reset
REQ-029 reset low asynchronously forces: state IDLE, last=1 (m0 first), counter 0, all latches 0.
REQ-030 Reset values: address, data_out, m0/m1_data_in = 8'h00; read, write, m0/m1_ready, err = 0; grant = 00.
REQ-031 Reset mid-transaction drops read/write immediately; no mx_ready issued for the aborted access.

Structure
REQ-032 Package bus_arb_pkg holds DATA_W=8, ADDR_W=8, state encodings and the timeout read value 8'hFF.
REQ-033 Sub-module bus_arb_timer holds wait counter and timeout compare (inputs clr, en, TIMEOUT; output expired).

Verification
REQ-034 m0_read, m0_address=8'h10, slave ready after 2 cycles with data_in=8'hA5 -> read high 3 cycles, m0_data_in=8'hA5, m0_ready pulse, grant=01 throughout.
REQ-035 m0 and m1 write same cycle after reset (data 8'h11/8'h22) -> m0 served first, one DONE+IDLE gap, then m1; data_out 8'h11 then 8'h22.
REQ-036 m1_read, ready never asserted, TIMEOUT=15 -> after 15 BUS1 cycles, err and m1_ready pulse together, m1_data_in=8'hFF.
REQ-037 m0_read and m0_write both high -> no grant, bus idle; m1 request same cycle -> granted normally.
REQ-038 reset low during BUS1 wait -> read/write low same cycle, grant=00, no m1_ready; after release, new m0 request served normally.
REQ-039 ready coincident with counter=TIMEOUT -> normal completion, err stays 0, real data_in returned.
